// File: rtl/fb_muldiv.sv
// fb_muldiv -- RV32M multiply/divide unit sitting beside the EX stage.
// Multiply is iterative shift-add on operand magnitudes, and divide is restoring
// division on magnitudes. Each runs one bit per cycle over 32 CALC cycles.
// Divide-by-zero and signed overflow finish straight from IDLE.
// Datapath width comes from the global define `FB_32BITS (default 32).
// Build option FB_MULDIV_FAST_MUL_EN: when defined, all multiplies are computed
// in a single combinational step and go IDLE -> DONE. Divide is unaffected.
`ifndef FB_32BITS
`define FB_32BITS 32
`endif

module fb_muldiv (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  md_start,
  input  logic                  md_flush,
  input  logic [2:0]            md_op,
  input  logic [`FB_32BITS-1:0] md_rs1,
  input  logic [`FB_32BITS-1:0] md_rs2,
  input  logic [4:0]            md_rd,
  output logic                  md_stall,
  output logic                  md_busy,
  output logic                  md_valid,
  output logic [`FB_32BITS-1:0] md_result,
  output logic [4:0]            md_wb_rd
);

  localparam int W = `FB_32BITS;
  localparam logic [5:0]   LAST_CNT = 6'(W - 1);
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0] MIN_INT  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] { IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2 } state_t;

  state_t         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;
  logic [4:0]     rd_q, rd_d;
  logic           neg_q, neg_d;
  logic [W-1:0]   b_q, b_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic           busy_q, busy_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   result_q, result_d;
  logic [4:0]     wb_rd_q, wb_rd_d;

  logic           s1_signed, s2_signed, rs1_neg, rs2_neg;
  logic           div_zero, div_ovf, neg_in;
  logic [W-1:0]   a_mag, b_mag, special_res;

  logic [W:0]     mul_sum, rem_sh;
  logic [W-1:0]   div_diff, div_val, calc_res;
  logic [2*W-1:0] mul_step, div_step, acc_step, prod;

  // Decode the incoming op: operand signedness, magnitudes, result sign, early-out cases.
  always_comb begin
    s1_signed = md_op[2] ? ~md_op[0] : ~(md_op[1] & md_op[0]);
    s2_signed = md_op[2] ? ~md_op[0] : ~md_op[1];
    rs1_neg   = s1_signed & md_rs1[W-1];
    rs2_neg   = s2_signed & md_rs2[W-1];
    a_mag     = rs1_neg ? ({W{1'b0}} - md_rs1) : md_rs1;
    b_mag     = rs2_neg ? ({W{1'b0}} - md_rs2) : md_rs2;
    // Remainder follows the dividend sign; everything else is the XOR of signs.
    neg_in    = (md_op[2] & md_op[1]) ? rs1_neg : (rs1_neg ^ rs2_neg);
    div_zero  = md_op[2] & (md_rs2 == {W{1'b0}});
    div_ovf   = md_op[2] & ~md_op[0] & (md_rs1 == MIN_INT) & (md_rs2 == ALL_ONES);
    if (md_op[1]) begin
      special_res = div_zero ? md_rs1 : {W{1'b0}};
    end else begin
      special_res = div_zero ? ALL_ONES : MIN_INT;
    end
  end

  // One shift-add or restoring-divide iteration on acc, plus the sign-corrected result.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
    mul_step = {mul_sum, acc_q[W-1:1]};
    rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
    // Partial remainder stays below the divisor, so the W-bit difference is exact.
    div_diff = rem_sh[W-1:0] - b_q;
    if (rem_sh >= {1'b0, b_q}) begin
      div_step = {div_diff, acc_q[W-2:0], 1'b1};
    end else begin
      div_step = {acc_q[2*W-2:0], 1'b0};
    end
    acc_step = op_q[2] ? div_step : mul_step;
    prod     = neg_q ? ({(2*W){1'b0}} - acc_step) : acc_step;
    div_val  = op_q[1] ? acc_step[2*W-1:W] : acc_step[W-1:0];
    if (op_q[2]) begin
      calc_res = neg_q ? ({W{1'b0}} - div_val) : div_val;
    end else if (op_q[1:0] == 2'b00) begin
      calc_res = prod[W-1:0];
    end else begin
      calc_res = prod[2*W-1:W];
    end
  end

`ifdef FB_MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fast_mag, fast_prod;
  logic [W-1:0]   fast_res;

  // Single-step multiply of the incoming operands.
  always_comb begin
    fast_mag  = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
    fast_prod = neg_in ? ({(2*W){1'b0}} - fast_mag) : fast_mag;
    if (md_op[1:0] == 2'b00) begin
      fast_res = fast_prod[W-1:0];
    end else begin
      fast_res = fast_prod[2*W-1:W];
    end
  end
`endif

  // Next-state logic: acceptance, iteration, early completion and flush.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    b_d      = b_q;
    acc_d    = acc_q;
    busy_d   = 1'b0;
    valid_d  = 1'b0;
    result_d = result_q;
    wb_rd_d  = wb_rd_q;
    case (state_q)
      IDLE: begin
        if (md_start & ~md_flush) begin
          op_d  = md_op;
          rd_d  = md_rd;
          neg_d = neg_in;
          b_d   = b_mag;
          acc_d = {{W{1'b0}}, a_mag};
          cnt_d = 6'd0;
          if (div_zero | div_ovf) begin
            state_d  = DONE;
            valid_d  = 1'b1;
            result_d = special_res;
            wb_rd_d  = md_rd;
          end
`ifdef FB_MULDIV_FAST_MUL_EN
          else if (~md_op[2]) begin
            state_d  = DONE;
            valid_d  = 1'b1;
            result_d = fast_res;
            wb_rd_d  = md_rd;
          end
`endif
          else begin
            state_d = CALC;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (md_flush) begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end else begin
          acc_d = acc_step;
          if (cnt_q == LAST_CNT) begin
            state_d  = DONE;
            cnt_d    = 6'd0;
            valid_d  = 1'b1;
            result_d = calc_res;
            wb_rd_d  = rd_q;
          end else begin
            cnt_d  = cnt_q + 6'd1;
            busy_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      op_q     <= 3'd0;
      rd_q     <= 5'd0;
      neg_q    <= 1'b0;
      b_q      <= {W{1'b0}};
      acc_q    <= {(2*W){1'b0}};
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= {W{1'b0}};
      wb_rd_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      wb_rd_q  <= wb_rd_d;
    end
  end

  assign md_stall  = (state_q == CALC) | ((state_q == IDLE) & md_start & ~md_flush);
  assign md_busy   = busy_q;
  assign md_valid  = valid_q;
  assign md_result = result_q;
  assign md_wb_rd  = wb_rd_q;

endmodule
